// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data-memory responder slice.
package mips_mem_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned MAX_WAIT_CYCLES = 15;
    localparam int unsigned WAIT_CNT_W      = $clog2(MAX_WAIT_CYCLES + 1);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_wait_counter.sv
// Wait-state down-counter: loads on request acceptance, counts down while waiting.
module dmem_wait_counter
    import mips_mem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_value_i,
    input  logic                  dec_i,
    output logic                  done_o
);

    logic [WAIT_CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with fixed wait-state latency and valid/ready handshakes.
// Optional misaligned-access rejection: define DMEM_RESP_ALIGN_CHECK_EN.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [WORD_W-1:0] req_write_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_read_data,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e      state_q;
    logic             req_ready_q, resp_valid_q, resp_err_q;
    word_t            resp_data_q;
    logic             write_q, misaligned_q;
    logic [IDX_W-1:0] idx_q;
    word_t            wdata_q;
    word_t            mem_q [DEPTH_WORDS];

    logic             accept, cnt_done, enter_resp, in_idle;
    logic             misaligned_d, eff_write, eff_mis;
    logic [IDX_W-1:0] eff_idx;
    word_t            eff_wdata, resp_data_d;
    logic             addr_unused;

    assign accept  = req_valid && req_ready_q;
    assign in_idle = (state_q == IDLE);

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    assign misaligned_d = (req_address[1:0] != 2'b00);
`else
    assign misaligned_d = 1'b0;
`endif
    assign addr_unused = ^{req_address[ADDR_W-1:IDX_W+2], req_address[1:0]};

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the live request fields must be used instead of the captured ones.
    assign eff_write = in_idle ? req_write                 : write_q;
    assign eff_idx   = in_idle ? req_address[IDX_W+1:2]    : idx_q;
    assign eff_wdata = in_idle ? req_write_data            : wdata_q;
    assign eff_mis   = in_idle ? misaligned_d              : misaligned_q;

    assign enter_resp = (accept && (WAIT_CYCLES == 0))
                     || ((state_q == WAIT) && cnt_done);

    always_comb begin
        resp_data_d = '0;
        if (!eff_write && !eff_mis) begin
            resp_data_d = mem_q[eff_idx];
        end
    end

    dmem_wait_counter u_wait_cnt (
        .clk_i       (clk),
        .rst_ni      (nrst),
        .load_i      (accept),
        .load_value_i(WAIT_LOAD),
        .dec_i       (state_q == WAIT),
        .done_o      (cnt_done)
    );

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && eff_write && !eff_mis) begin
            mem_q[eff_idx] <= eff_wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            write_q      <= 1'b0;
            misaligned_q <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q      <= req_write;
                        idx_q        <= req_address[IDX_W+1:2];
                        wdata_q      <= req_write_data;
                        misaligned_q <= misaligned_d;
                        req_ready_q  <= 1'b0;
                        state_q      <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_done) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= resp_data_d;
                resp_err_q   <= eff_mis;
            end
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_read_data = resp_data_q;
    assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 with two wait states, instance 1 with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_address [2];
    logic [31:0] req_write_data [2];
    logic [31:0] resp_read_data [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_address(req_address[0]), .req_write_data(req_write_data[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_read_data(resp_read_data[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_address(req_address[1]), .req_write_data(req_write_data[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_read_data(resp_read_data[1]), .resp_err(resp_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit exp_misaligned(input logic [31:0] a);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: phase 0 idle, 1 waiting, 2 responding.
    int          m_phase [2];
    int          m_rem [2];
    logic        m_wr [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_data [2];
    logic        m_err [2];
    bit          m_fresh [2];
    logic [31:0] m_mem [2][256];

    task automatic respond(input int k, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx;
        idx = (a / 4) % 256;
        m_fresh[k] <= 1'b0;
        if (exp_misaligned(a)) begin
            m_err[k]  <= 1'b1;
            m_data[k] <= '0;
        end else begin
            m_err[k] <= 1'b0;
            if (wr) begin
                m_mem[k][idx] <= wd;
                m_data[k]     <= '0;
            end else begin
                m_data[k] <= m_mem[k][idx];
            end
        end
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= 0;
                m_rem[k]   <= 0;
                m_data[k]  <= '0;
                m_err[k]   <= 1'b0;
                m_fresh[k] <= 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (m_phase[k])
                    0: if (req_valid[k]) begin
                        m_wr[k]   <= req_write[k];
                        m_addr[k] <= req_address[k];
                        m_wd[k]   <= req_write_data[k];
                        if (wait_of(k) == 0) begin
                            m_phase[k] <= 2;
                            respond(k, req_write[k], req_address[k], req_write_data[k]);
                        end else begin
                            m_phase[k] <= 1;
                            m_rem[k]   <= wait_of(k);
                        end
                    end
                    1: if (m_rem[k] == 1) begin
                        m_phase[k] <= 2;
                        respond(k, m_wr[k], m_addr[k], m_wd[k]);
                    end else begin
                        m_rem[k] <= m_rem[k] - 1;
                    end
                    default: if (resp_ready[k]) m_phase[k] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("req_ready%0d", k), {31'b0, req_ready[k]}, {31'b0, m_phase[k] == 0});
            check($sformatf("resp_valid%0d", k), {31'b0, resp_valid[k]}, {31'b0, m_phase[k] == 2});
            if (m_phase[k] == 2 || m_fresh[k]) begin
                check($sformatf("resp_data%0d", k), resp_read_data[k], m_data[k]);
                check($sformatf("resp_err%0d", k), {31'b0, resp_err[k]}, {31'b0, m_err[k]});
            end
        end
    end

    task automatic txn(input int k, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int hold, output logic [31:0] data, output logic err, output int lat);
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_address[k] = a;
        req_write_data[k] = wd;
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_address[k] = $urandom;
        req_write_data[k] = $urandom;
        lat = 1;
        while (!resp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        data = resp_read_data[k];
        err = resp_err[k];
        repeat (hold) @(negedge clk);
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
    endtask

    task automatic reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_ready"}, {31'b0, req_ready[k]}, 32'd1);
            check({tag, "_valid"}, {31'b0, resp_valid[k]}, 32'd0);
            check({tag, "_data"}, resp_read_data[k], 32'd0);
            check({tag, "_err"}, {31'b0, resp_err[k]}, 32'd0);
        end
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;

    initial begin
        req_valid = '0; req_write = '0; resp_ready = '0;
        for (int k = 0; k < 2; k++) begin
            req_address[k] = '0;
            req_write_data[k] = '0;
        end
        nrst = 1'b1;
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        reset_values("rst");
        #2 nrst = 1'b1;

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, d, e, lat);
        check("st_lat_w2", lat, 3);
        txn(0, 1'b0, 32'h10, 32'h0, 0, d, e, lat);
        check("ld_data_w2", d, 32'hDEADBEEF);
        check("ld_lat_w2", lat, 3);

        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0, d, e, lat);
        check("st_lat_w0", lat, 1);
        txn(1, 1'b0, 32'h10, 32'h0, 0, d, e, lat);
        check("ld_data_w0", d, 32'hDEADBEEF);
        check("ld_lat_w0", lat, 1);

        txn(0, 1'b1, 32'h400, 32'h12345678, 0, d, e, lat);
        check("st_data_zero", d, 32'h0);
        txn(0, 1'b0, 32'h000, 32'h0, 5, d, e, lat);
        check("ld_wrap", d, 32'h12345678);
        txn(1, 1'b1, 32'h7FC, 32'hCAFEF00D, 2, d, e, lat);
        txn(1, 1'b0, 32'h3FC, 32'h0, 0, d, e, lat);
        check("ld_wrap_top", d, 32'hCAFEF00D);

        txn(0, 1'b1, 32'h20, 32'hA5A5A5A5, 0, d, e, lat);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1;
        req_address[0] = 32'h20; req_write_data[0] = 32'hFFFFFFFF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        #2 nrst = 1'b0;
        @(negedge clk);
        reset_values("abort");
        @(negedge clk);
        #2 nrst = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, 0, d, e, lat);
        check("ld_after_abort", d, 32'hA5A5A5A5);

        txn(0, 1'b1, 32'h22, 32'h00000055, 1, d, e, lat);
        check("st_mis_lat", lat, 3);
        txn(0, 1'b0, 32'h20, 32'h0, 0, d, e, lat);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        check("ld_after_mis_st", d, 32'hA5A5A5A5);
`else
        check("ld_after_mis_st", d, 32'h00000055);
`endif
        txn(1, 1'b0, 32'h13, 32'h0, 0, d, e, lat);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        check("ld_mis_err", {31'b0, e}, 32'd1);
        check("ld_mis_data", d, 32'h0);
`else
        check("ld_mis_err", {31'b0, e}, 32'd0);
        check("ld_mis_data", d, 32'hDEADBEEF);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words stored (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nrst  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  meaning the core presents a memory request.
REQ-006 The block SHALL have port req_ready  output  1  meaning the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_write  input  1  meaning the request is a store; 0 means a load.
REQ-008 The block SHALL have port req_address  input  32  meaning the byte address; only the word index is used.
REQ-009 The block SHALL have port req_write_data  input  32  meaning the store data.
REQ-010 The block SHALL have port resp_valid  output  1  meaning a response is presented.
REQ-011 The block SHALL have port resp_ready  input  1  meaning the core consumes the response this cycle.
REQ-012 The block SHALL have port resp_read_data  output  32  meaning the load data; 0 for stores.
REQ-013 The block SHALL have port resp_err  output  1  meaning the request was rejected (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted when req_valid and req_ready are both 1; req_write, req_address and req_write_data SHALL be captured on that edge.
REQ-016 After acceptance the FSM SHALL go to WAIT if WAIT_CYCLES>0, otherwise directly to RESP.
REQ-017 In WAIT a counter SHALL load WAIT_CYCLES-1 on entry, decrement each cycle, and move to RESP on the cycle after it reaches 0.
REQ-018 With acceptance on cycle N, resp_valid SHALL first be 1 on cycle N+1+WAIT_CYCLES.
REQ-019 Stores SHALL update the memory array on the edge that enters RESP; loads SHALL register the addressed word on that same edge.
REQ-020 In RESP, resp_valid, resp_read_data and resp_err SHALL hold stable until resp_ready is 1; the FSM SHALL then return to IDLE on that edge.
REQ-021 No new request SHALL be accepted in the cycle resp_ready completes a response; the earliest next acceptance is the following cycle.
REQ-022 The word index SHALL be req_address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 Changes on req_* inputs outside the acceptance cycle SHALL have no effect.

Reset
REQ-024 On nrst low, the FSM SHALL enter IDLE and the wait counter SHALL clear, asynchronously.
REQ-025 During and after reset, req_ready SHALL be 1, resp_valid 0, resp_read_data 0 and resp_err 0.
REQ-026 A reset during WAIT SHALL abort the request without writing memory.
REQ-027 The memory array SHALL NOT be cleared by reset.

Configuration
REQ-028 With DMEM_RESP_ALIGN_CHECK_EN defined, a request with req_address[1:0]!=0 SHALL produce resp_err=1 and resp_read_data=0, SHALL NOT write memory, and SHALL keep normal latency.
REQ-029 Without DMEM_RESP_ALIGN_CHECK_EN, resp_err SHALL be constant 0 and req_address[1:0] SHALL be ignored.

Structure
REQ-030 Package mips_mem_pkg SHALL hold the FSM state enum, the 32-bit word and address width constants, and the maximum WAIT_CYCLES constant.
REQ-031 The wait-state counter SHALL be a sub-module named dmem_wait_counter, with load, decrement and a done output.

Verification
REQ-032 Reset, then store 0xDEADBEEF at 0x10 and load from 0x10 with WAIT_CYCLES=2: the load response SHALL be 0xDEADBEEF, 3 cycles after acceptance.
REQ-033 WAIT_CYCLES=0, load from 0x10 after the store above: resp_valid SHALL be 1 on the cycle after acceptance with 0xDEADBEEF.
REQ-034 Hold resp_ready=0 for 5 cycles in RESP: response outputs SHALL be stable and req_ready SHALL be 0 throughout; on resp_ready=1 the FSM SHALL return to IDLE.
REQ-035 DEPTH_WORDS=256, store 0x12345678 at 0x400, then load from 0x000: the result SHALL be 0x12345678 (wrap).
REQ-036 Assert nrst low during WAIT of a store of 0xFFFFFFFF to 0x20, then load from 0x20: the prior contents SHALL be returned, and outputs SHALL be at reset values while nrst is low.
REQ-037 With DMEM_RESP_ALIGN_CHECK_EN, store to 0x22: resp_err SHALL be 1, and a later load from 0x20 SHALL return the unchanged word.
